// File: rtl/spike_scheduler.sv
// spike_scheduler: circular delay store of axon spikes. Each tick captures
// the current slot into a shadow bitmap and drains it, lowest axon first,
// to the neuron controller over a valid/ready handshake.
module spike_scheduler #(
  parameter int N_AXONS     = 256,
  parameter int AXON_W      = 8,
  parameter int DELAY_SLOTS = 16,
  parameter int DELAY_W     = 4,
  parameter int PKT_SIZE    = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                in_valid,
  input  logic [PKT_SIZE-1:0] in_pkt,
  output logic                in_ready,
  output logic [PKT_SIZE-1:0] from_sched,
  output logic                flag_from_sched,
  input  logic                ctrl_ready,
  output logic [DELAY_W-1:0]  cur_slot,
  output logic                busy,
  output logic                overrun
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [0:0]                             state;
  logic [DELAY_SLOTS-1:0][N_AXONS-1:0]    store;
  logic [N_AXONS-1:0]                     shadow, shadow_nxt;
  logic [DELAY_W-1:0]                     slot_nxt, wr_slot, pkt_delay;
  logic [AXON_W-1:0]                      pkt_axon, lo_idx;
  logic                                   lo_any, xfer, wr_en;

  // The store never fills: every (slot, axon) pair has its own bit.
  assign in_ready  = 1'b1;
  assign wr_en     = in_valid & in_ready;
  assign pkt_delay = in_pkt[PKT_SIZE-1 -: DELAY_W];
  assign pkt_axon  = in_pkt[AXON_W-1:0];
  assign slot_nxt  = (cur_slot == DELAY_W'(DELAY_SLOTS-1)) ? '0 : cur_slot + 1'b1;
  // A write alongside a tick is placed relative to the advanced pointer, so
  // it can never land in the slot being captured this edge.
  assign wr_slot   = (tick ? slot_nxt : cur_slot) + pkt_delay;
  assign xfer      = flag_from_sched & ctrl_ready;
  assign busy      = (state == DRAIN);

  // Shadow as it will look after this edge's accepted transfer, if any.
  always_comb begin
    shadow_nxt = shadow;
    if (xfer) shadow_nxt[from_sched[AXON_W-1:0]] = 1'b0;
  end

  // Lowest set bit of the post-transfer shadow picks the next packet.
  always_comb begin
    lo_idx = '0;
    lo_any = |shadow_nxt;
    for (int i = N_AXONS-1; i >= 0; i--)
      if (shadow_nxt[i]) lo_idx = AXON_W'(i);
  end

  // Delay store: tick clears the captured slot, then a write may set a bit
  // (a write targeting the same index under the new pointer survives).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      store <= '0;
    end else begin
      if (tick)  store[cur_slot]          <= '0;
      if (wr_en) store[wr_slot][pkt_axon] <= 1'b1;
    end
  end

  // Slot pointer advances once per tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur_slot <= '0;
    else if (tick) cur_slot <= slot_nxt;
  end

  // Drain FSM, shadow bitmap and registered output packet.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      shadow          <= '0;
      flag_from_sched <= 1'b0;
      from_sched      <= '0;
      overrun         <= 1'b0;
    end else if (tick) begin
      // Bits still owed from the previous slot are lost; flag it stickily.
      if (state == DRAIN && (|shadow_nxt)) overrun <= 1'b1;
      shadow          <= store[cur_slot];
      state           <= DRAIN;
      flag_from_sched <= 1'b0;
      from_sched      <= '0;
    end else if (state == DRAIN) begin
      shadow <= shadow_nxt;
      if (!(flag_from_sched && !ctrl_ready)) begin
        flag_from_sched <= lo_any;
        from_sched      <= lo_any ? {{DELAY_W{1'b0}}, lo_idx} : '0;
      end
      if (!(|shadow) && !flag_from_sched) state <= IDLE;
    end
  end

endmodule

// File: tb/tb_spike_scheduler.sv
// Bench for spike_scheduler: directed scenarios plus random traffic, all
// checked against a slot/queue reference model.
module tb_spike_scheduler;
  logic        clk = 1'b0, reset = 1'b1, tick = 1'b0, in_valid = 1'b0, ctrl_ready = 1'b0;
  logic [11:0] in_pkt = '0;
  logic        in_ready, flag_from_sched, busy, overrun;
  logic [11:0] from_sched;
  logic [3:0]  cur_slot;

  spike_scheduler dut (
    .clk(clk), .reset(reset), .tick(tick), .in_valid(in_valid), .in_pkt(in_pkt),
    .in_ready(in_ready), .from_sched(from_sched), .flag_from_sched(flag_from_sched),
    .ctrl_ready(ctrl_ready), .cur_slot(cur_slot), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, n_xfer = 0;
  // Reference: one bit per (slot, axon), a pointer, and the ascending list
  // of axons still owed from the last captured slot.
  bit mstore [16][256];
  int mcur = 0;
  bit m_ovr = 1'b0;
  int q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] head();
    return (q.size() != 0) ? 32'(q[0]) : 32'hFFF;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 16; s++)
      for (int a = 0; a < 256; a++) mstore[s][a] = 1'b0;
    mcur = 0; m_ovr = 1'b0; q.delete();
  endfunction

  // One clock: drive inputs, take the edge, advance the model, check.
  task automatic step(input logic tk, input logic v, input logic [11:0] pkt, input logic rdy);
    logic        pre_f;
    logic [11:0] pre_fs;
    int          tgt;
    tick = tk; in_valid = v; in_pkt = pkt; ctrl_ready = rdy;
    pre_f = flag_from_sched; pre_fs = from_sched;
    @(posedge clk); #1;
    if (pre_f && rdy) begin
      chk("xfer", 32'(pre_fs), head());
      n_xfer++;
      if (q.size() != 0) void'(q.pop_front());
    end
    if (pre_f && !rdy && !tk) begin
      chk("hold_flag", 32'(flag_from_sched), 1);
      chk("hold_pkt", 32'(from_sched), 32'(pre_fs));
    end
    if (tk) begin
      if (q.size() != 0) m_ovr = 1'b1;
      q.delete();
      for (int a = 0; a < 256; a++)
        if (mstore[mcur][a]) begin q.push_back(a); mstore[mcur][a] = 1'b0; end
      mcur = (mcur + 1) % 16;
    end
    if (v) begin
      tgt = (mcur + int'(pkt[11:8])) % 16;
      mstore[tgt][pkt[7:0]] = 1'b1;
    end
    chk("cur_slot", 32'(cur_slot), 32'(mcur));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("in_ready", 32'(in_ready), 1);
    if (flag_from_sched) chk("head", 32'(from_sched), head());
    @(negedge clk);
    tick = 1'b0; in_valid = 1'b0;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 12'h000, rdy);
  endtask

  // Reset asserted mid-cycle; outputs must clear without waiting for an edge.
  task automatic async_reset();
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("rst_flag", 32'(flag_from_sched), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_slot", 32'(cur_slot), 0);
    chk("rst_ovr", 32'(overrun), 0);
    chk("rst_pkt", 32'(from_sched), 0);
    chk("rst_rdy", 32'(in_ready), 1);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int n0;
    logic [11:0] p;
    async_reset();

    // Single spike, delay 0, with explicit latency/busy timing.
    step(1'b0, 1'b1, {4'd0, 8'd8}, 1'b1);
    step(1'b1, 1'b0, 12'h000, 1'b1);
    chk("t1_busy_tick", 32'(busy), 1);
    chk("t1_flag_tick", 32'(flag_from_sched), 0);
    step(1'b0, 1'b0, 12'h000, 1'b1);
    chk("t1_flag", 32'(flag_from_sched), 1);
    chk("t1_pkt", 32'(from_sched), 32'h008);
    step(1'b0, 1'b0, 12'h000, 1'b1);
    chk("t1_flag_done", 32'(flag_from_sched), 0);
    chk("t1_busy_after", 32'(busy), 1);
    step(1'b0, 1'b0, 12'h000, 1'b1);
    chk("t1_busy_fall", 32'(busy), 0);
    chk("t1_slot", 32'(cur_slot), 1);
    chk("t1_cnt", 32'(n_xfer), 1);

    // Delay 2 with a duplicate: nothing until the third tick, then 3, 200.
    step(1'b0, 1'b1, {4'd2, 8'd3}, 1'b1);
    step(1'b0, 1'b1, {4'd2, 8'd200}, 1'b1);
    step(1'b0, 1'b1, {4'd2, 8'd3}, 1'b1);
    n0 = n_xfer;
    step(1'b1, 1'b0, 12'h000, 1'b1); idle(3, 1'b1);
    step(1'b1, 1'b0, 12'h000, 1'b1); idle(3, 1'b1);
    chk("t2_early", 32'(n_xfer - n0), 0);
    step(1'b1, 1'b0, 12'h000, 1'b1); idle(5, 1'b1);
    chk("t2_cnt", 32'(n_xfer - n0), 2);

    // Back-pressure: ctrl_ready toggles, packets must hold.
    step(1'b0, 1'b1, {4'd0, 8'd5}, 1'b1);
    step(1'b0, 1'b1, {4'd0, 8'd1}, 1'b1);
    step(1'b0, 1'b1, {4'd0, 8'd2}, 1'b1);
    n0 = n_xfer;
    step(1'b1, 1'b0, 12'h000, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 12'h000, logic'(i % 2));
    chk("t3_cnt", 32'(n_xfer - n0), 3);

    // Tick and write together: axon 7 waits for the following tick.
    n0 = n_xfer;
    step(1'b1, 1'b1, {4'd0, 8'd7}, 1'b1); idle(4, 1'b1);
    chk("t4_not_now", 32'(n_xfer - n0), 0);
    step(1'b1, 1'b0, 12'h000, 1'b1); idle(4, 1'b1);
    chk("t4_later", 32'(n_xfer - n0), 1);

    // Overrun: second tick while 10 axons are stuck behind ctrl_ready=0.
    for (int a = 10; a < 20; a++) step(1'b0, 1'b1, {4'd0, 8'(a)}, 1'b0);
    step(1'b0, 1'b1, {4'd1, 8'd99}, 1'b0);
    step(1'b1, 1'b0, 12'h000, 1'b0); idle(3, 1'b0);
    chk("t5_no_ovr", 32'(overrun), 0);
    step(1'b1, 1'b0, 12'h000, 1'b0);
    chk("t5_ovr", 32'(overrun), 1);
    n0 = n_xfer;
    idle(6, 1'b1);
    chk("t5_cnt", 32'(n_xfer - n0), 1);
    idle(3, 1'b1);
    chk("t5_sticky", 32'(overrun), 1);

    // Pointer wrap, then delay 15 from slot 0 lands on the 16th tick.
    async_reset();
    for (int i = 0; i < 16; i++) begin step(1'b1, 1'b0, 12'h000, 1'b1); idle(1, 1'b1); end
    chk("t6_wrap", 32'(cur_slot), 0);
    step(1'b0, 1'b1, {4'd15, 8'd77}, 1'b1);
    n0 = n_xfer;
    for (int i = 0; i < 15; i++) begin step(1'b1, 1'b0, 12'h000, 1'b1); idle(2, 1'b1); end
    chk("t6_early", 32'(n_xfer - n0), 0);
    step(1'b1, 1'b0, 12'h000, 1'b1); idle(3, 1'b1);
    chk("t6_cnt", 32'(n_xfer - n0), 1);

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      p = 12'($urandom);
      step(logic'($urandom_range(0, 7) == 0), logic'($urandom_range(0, 1)), p,
           logic'($urandom_range(0, 3) != 0));
    end
    idle(4, 1'b1);

    // Reset in the middle of a drain discards everything.
    async_reset();
    for (int a = 40; a < 45; a++) step(1'b0, 1'b1, {4'd0, 8'(a)}, 1'b1);
    step(1'b1, 1'b0, 12'h000, 1'b1);
    step(1'b0, 1'b0, 12'h000, 1'b1);
    chk("t7_flag_pre", 32'(flag_from_sched), 1);
    async_reset();
    n0 = n_xfer;
    idle(6, 1'b1);
    chk("t7_cnt", 32'(n_xfer - n0), 0);
    chk("t7_busy", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
